// File: rtl/i2s_pkg.sv
// Shared definitions for the multi-lane I2S capture front-end: slot encodings,
// overrun counter width and the frame-vector width helper.
package i2s_pkg;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  localparam int OVR_CNT_W = 16;

  function automatic int frame_w(input int nch, input int dw);
    return nch * dw;
  endfunction

endpackage

// File: rtl/vr_fifo.sv
// Small frame FIFO with push/full and pop/empty; the read port holds the last
// popped word while empty so downstream sees a stable value.
module vr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  output logic             o_full,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_last;
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO is accepted.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? r_last : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_last <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_wdata;
        r_wr                <= r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_last <= r_mem[r_rd[AW-1:0]];
        r_rd   <= r_rd + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_rx_array.sv
// Multi-lane I2S receiver: one SCK/WS generator, per-lane MSB-first shifters,
// frame-vector FIFO on a valid/ready port, and saturating overrun accounting.
module i2s_rx_array
  import i2s_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int DW         = 16,
  parameter int SLOT_BITS  = 32,
  parameter int PER_W      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [PER_W-1:0]             cfg_half_per,
  input  logic                         cfg_slot,
  input  logic [NCH-1:0]               cfg_ch_en,
  output logic                         sck,
  output logic                         ws,
  input  logic [NCH-1:0]               sd,
  output logic [frame_w(NCH,DW)-1:0]   dout,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic                         overrun_pulse,
  output logic [OVR_CNT_W-1:0]         overrun_cnt
);

  localparam int FW = frame_w(NCH, DW);
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] SB     = BW'(SLOT_BITS);
  localparam logic [BW-1:0] K_LAST = BW'(DW);

  // Handshake: a frame moves out on any clk edge where dout_vld && dout_rdy;
  // dout is the FIFO head and stays put while dout_vld && !dout_rdy.

  logic                  r_en_d;
  logic [PER_W-1:0]      r_div;
  logic                  r_sck;
  logic [BW-1:0]         r_b;
  logic [PER_W-1:0]      r_half_per;
  slot_e                 r_slot;
  logic [NCH-1:0]        r_ch_en;
  logic [DW-1:0]         r_sh [NCH];
  logic                  r_ovr_pulse;
  logic [OVR_CNT_W-1:0]  r_ovr_cnt;

  logic [PER_W-1:0]      w_half;
  logic                  w_run;
  logic                  w_tick;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_hi;
  logic [BW-1:0]         w_k;
  logic                  w_samp;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic [DW-1:0]         w_next [NCH];
  logic [FW-1:0]         w_frame;

  assign w_half = (r_half_per == '0) ? PER_W'(1) : r_half_per;
  // The first enabled cycle only latches config; the generator starts on the next one.
  assign w_run  = enable & r_en_d;
  assign w_tick = w_run & (r_div == (w_half - PER_W'(1)));
  assign w_rise = w_tick & ~r_sck;
  assign w_fall = w_tick & r_sck;
  assign w_hi   = (r_b >= SB);
  assign w_k    = w_hi ? (r_b - SB) : r_b;
  // Slot bit 0 is the I2S one-bit delay; bits 1..DW carry the word MSB first.
  assign w_samp = w_rise & (w_hi == (r_slot == SLOT_RIGHT)) &
                  (w_k >= BW'(1)) & (w_k <= K_LAST);
  assign w_push = w_samp & (w_k == K_LAST);
  assign w_pop  = dout_rdy & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  always_comb begin
    w_frame = '0;
    for (int i = 0; i < NCH; i++) begin
      w_next[i] = {r_sh[i][DW-2:0], sd[i]};
      if (r_ch_en[i]) w_frame[i*DW +: DW] = w_next[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d      <= 1'b0;
      r_div       <= '0;
      r_sck       <= 1'b0;
      r_b         <= '0;
      r_half_per  <= '0;
      r_slot      <= SLOT_LEFT;
      r_ch_en     <= '0;
      r_ovr_pulse <= 1'b0;
      r_ovr_cnt   <= '0;
      for (int i = 0; i < NCH; i++) r_sh[i] <= '0;
    end else begin
      r_en_d      <= enable;
      r_ovr_pulse <= w_drop;
      if (w_drop && (r_ovr_cnt != '1)) r_ovr_cnt <= r_ovr_cnt + 1'b1;

      if (!w_run) begin
        r_div <= '0;
        r_sck <= 1'b0;
        r_b   <= '0;
        for (int i = 0; i < NCH; i++) r_sh[i] <= '0;
        if (enable) begin
          r_half_per <= cfg_half_per;
          r_slot     <= slot_e'(cfg_slot);
          r_ch_en    <= cfg_ch_en;
        end
      end else begin
        if (w_tick) begin
          r_div <= '0;
          r_sck <= ~r_sck;
        end else begin
          r_div <= r_div + 1'b1;
        end
        if (w_fall) begin
          if (r_b == B_LAST) begin
            // Frame boundary: the only point where running config may change.
            r_b        <= '0;
            r_half_per <= cfg_half_per;
            r_slot     <= slot_e'(cfg_slot);
            r_ch_en    <= cfg_ch_en;
          end else begin
            r_b <= r_b + 1'b1;
          end
        end
        if (w_samp) begin
          for (int i = 0; i < NCH; i++) r_sh[i] <= w_next[i];
        end
      end
    end
  end

  vr_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_frame),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_empty (w_empty),
    .o_rdata (dout)
  );

  assign sck           = r_sck;
  assign ws            = w_hi;
  assign dout_vld      = ~w_empty;
  assign overrun_pulse = r_ovr_pulse;
  assign overrun_cnt   = r_ovr_cnt;

endmodule

// File: tb/tb_i2s_rx_array.sv
// Bench for i2s_rx_array: an I2S transmitter model drives the lanes, and the
// expected frame vectors come from the words it sends in the selected slot.
module tb_i2s_rx_array;

  localparam int NCH = 4;
  localparam int DW = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int FW = NCH * DW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            enable;
  logic [7:0]      cfg_half_per;
  logic            cfg_slot;
  logic [NCH-1:0]  cfg_ch_en;
  logic            sck;
  logic            ws;
  logic [NCH-1:0]  sd;
  logic [FW-1:0]   dout;
  logic            dout_vld;
  logic            dout_rdy;
  logic            overrun_pulse;
  logic [15:0]     overrun_cnt;

  i2s_rx_array #(.NCH(NCH), .DW(DW), .SLOT_BITS(32), .PER_W(8), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cfg_half_per  (cfg_half_per),
    .cfg_slot      (cfg_slot),
    .cfg_ch_en     (cfg_ch_en),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .dout          (dout),
    .dout_vld      (dout_vld),
    .dout_rdy      (dout_rdy),
    .overrun_pulse (overrun_pulse),
    .overrun_cnt   (overrun_cnt)
  );

  // scoreboard
  logic [FW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int n_pop = 0;
  int n_gen = 0;
  int n_pulse = 0;
  int exp_drops = 0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // transmitter: word bits on slot bits 1..DW after each ws edge, junk elsewhere
  logic [DW-1:0] pat_l [NCH];
  logic [DW-1:0] pat_r [NCH];
  logic [DW-1:0] cur_l [NCH];
  logic [DW-1:0] cur_r [NCH];
  logic [DW-1:0] tx_word;
  logic [FW-1:0] tx_frame;
  bit   use_rand;
  int   tx_idx;
  logic tx_psck;
  logic tx_pws;
  bit   tx_load;

  always @(negedge clk) begin
    if (!rst_n || !enable) begin
      tx_idx  = 0;
      tx_psck = 1'b0;
      tx_pws  = 1'b0;
      tx_load = 1'b1;
      sd      = '0;
    end else begin
      if (tx_psck && !sck) begin
        if (ws != tx_pws) tx_idx = 0;
        else tx_idx++;
        if (tx_load || (tx_pws && !ws)) begin
          for (int i = 0; i < NCH; i++) begin
            cur_l[i] = use_rand ? DW'($urandom) : pat_l[i];
            cur_r[i] = use_rand ? DW'($urandom) : pat_r[i];
          end
          tx_load = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
          tx_word = ws ? cur_r[i] : cur_l[i];
          if (tx_idx >= 1 && tx_idx <= DW) sd[i] = tx_word[DW - tx_idx];
          else sd[i] = 1'($urandom_range(0, 1));
        end
        if (tx_idx == DW && ws == cfg_slot) begin
          tx_frame = '0;
          for (int i = 0; i < NCH; i++)
            if (cfg_ch_en[i]) tx_frame[i*DW +: DW] = cfg_slot ? cur_r[i] : cur_l[i];
          n_gen++;
          if (!dout_rdy && exp_q.size() >= FIFO_DEPTH) exp_drops++;
          else exp_q.push_back(tx_frame);
        end
        tx_pws = ws;
      end
      tx_psck = sck;
    end
  end

  // consumer side: every accepted frame is compared with the model head
  always @(negedge clk) begin
    if (rst_n && dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) check("unexpected_frame", FW'(0), FW'(1));
      else check("frame", dout, exp_q.pop_front());
      n_pop++;
    end
    if (rst_n && overrun_pulse) n_pulse++;
  end

  // driver tasks
  task automatic gen_on();
    @(posedge clk); #1 enable = 1'b1;
  endtask

  task automatic gen_off();
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    int start;
    start = n_pop;
    for (int c = 0; c < budget && n_pop < start + n; c++) @(negedge clk);
    check(tag, FW'(n_pop >= start + n), FW'(1));
  endtask

  task automatic wait_ws(input string tag, input logic lvl, input int budget);
    for (int c = 0; c < budget && ws !== lvl; c++) @(negedge clk);
    check(tag, FW'(ws), FW'(lvl));
  endtask

  task automatic measure(input bit use_ws, output int per);
    int n;
    logic prev, cur;
    n = 0;
    per = 0;
    prev = use_ws ? ws : sck;
    cur = prev;
    while (n < 2000) begin
      @(negedge clk); n++;
      cur = use_ws ? ws : sck;
      if (!prev && cur) break;
      prev = cur;
    end
    prev = cur;
    while (n < 2000) begin
      @(negedge clk); n++; per++;
      cur = use_ws ? ws : sck;
      if (!prev && cur) break;
      prev = cur;
    end
  endtask

  initial begin
    int per;
    int g0;
    int p0;
    logic [FW-1:0] v;
    rst_n = 1'b0;
    enable = 1'b0;
    cfg_half_per = 8'd2;
    cfg_slot = 1'b0;
    cfg_ch_en = '1;
    dout_rdy = 1'b1;
    use_rand = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      pat_l[i] = '0;
      pat_r[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_sck", FW'(sck), FW'(0));
    check("rst_ws", FW'(ws), FW'(0));
    check("rst_dout", dout, FW'(0));
    check("rst_vld", FW'(dout_vld), FW'(0));
    check("rst_ovr_pulse", FW'(overrun_pulse), FW'(0));
    check("rst_ovr_cnt", FW'(overrun_cnt), FW'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // 1) left slot, four directed lane words, timing of sck and ws
    pat_l[0] = 16'h8001; pat_l[1] = 16'h7FFF; pat_l[2] = 16'h1234; pat_l[3] = 16'hFFFF;
    for (int i = 0; i < NCH; i++) pat_r[i] = DW'($urandom);
    gen_on();
    measure(1'b0, per);
    check("t1_sck_period", FW'(per), FW'(4));
    measure(1'b1, per);
    check("t1_ws_period", FW'(per), FW'(256));
    wait_pops("t1_frame_seen", 1, 1200);
    gen_off();
    check("t1_idle_vld", FW'(dout_vld), FW'(0));

    // 2) right slot selected, left slot carries a different word
    cfg_slot = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      pat_l[i] = 16'hAAAA;
      pat_r[i] = 16'h5555;
    end
    gen_on();
    wait_pops("t2_frames_seen", 2, 1500);
    @(posedge clk); #1;
    check("t2_empty_vld", FW'(dout_vld), FW'(0));
    check("t2_hold_last", dout, {4{16'h5555}});
    gen_off();

    // 3) lanes 1 and 3 disabled
    cfg_slot = 1'b0;
    cfg_ch_en = 4'b0101;
    for (int i = 0; i < NCH; i++) pat_l[i] = DW'($urandom);
    gen_on();
    wait_pops("t3_frames_seen", 2, 1500);
    gen_off();

    // 4) consumer stalled for four frames with a two-entry FIFO
    cfg_ch_en = '1;
    use_rand = 1'b1;
    dout_rdy = 1'b0;
    g0 = n_gen;
    p0 = n_pulse;
    gen_on();
    for (int c = 0; c < 2000 && n_gen < g0 + 4; c++) @(negedge clk);
    check("t4_four_frames_sent", FW'(n_gen - g0), FW'(4));
    repeat (20) @(posedge clk);
    #1;
    check("t4_ovr_cnt", FW'(overrun_cnt), FW'(2));
    check("t4_ovr_cnt_model", FW'(overrun_cnt), FW'(exp_drops));
    check("t4_ovr_pulses", FW'(n_pulse - p0), FW'(2));
    check("t4_vld_held", FW'(dout_vld), FW'(1));
    v = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("t4_head_stable", dout, v);
    dout_rdy = 1'b1;
    wait_pops("t4_drain", 2, 20);
    @(posedge clk); #1;
    check("t4_drained_vld", FW'(dout_vld), FW'(0));
    gen_off();

    // 5) half-period changed mid-frame takes effect at the frame boundary
    gen_on();
    wait_ws("t5_in_right_half", 1'b1, 600);
    cfg_half_per = 8'd4;
    measure(1'b0, per);
    check("t5_sck_period_old", FW'(per), FW'(4));
    wait_ws("t5_frame_wrap", 1'b0, 600);
    measure(1'b0, per);
    check("t5_sck_period_new", FW'(per), FW'(8));
    wait_pops("t5_frame_seen", 1, 1200);
    gen_off();
    cfg_half_per = 8'd2;

    // 6) enable dropped mid-slot, then restored; then reset mid-frame
    gen_on();
    repeat (40) @(posedge clk);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_off_sck", FW'(sck), FW'(0));
    check("t6_off_ws", FW'(ws), FW'(0));
    check("t6_no_partial", FW'(dout_vld), FW'(0));
    gen_on();
    wait_pops("t6_frame_after_restart", 1, 600);
    dout_rdy = 1'b0;
    for (int c = 0; c < 600 && !dout_vld; c++) @(negedge clk);
    check("t6_frame_held", FW'(dout_vld), FW'(1));
    repeat (60) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_vld", FW'(dout_vld), FW'(0));
    check("t6_rst_dout", dout, FW'(0));
    check("t6_rst_ovr_cnt", FW'(overrun_cnt), FW'(0));
    check("t6_rst_sck", FW'(sck), FW'(0));
    exp_q.delete();
    enable = 1'b0;
    dout_rdy = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
